// File: rtl/mem_bus_ctrl.sv
// MEM-stage bus controller: decodes loads/stores into N_CH peripheral windows with ready/timeout.
// Latency: hit = 2 cycles + wait states (bounded by TIMEOUT), decode miss = 1 cycle.
// Backpressure: pipeline stall held until the one-cycle response; slow peripherals add wait states.
module mem_bus_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    N_CH       = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000,
    parameter int                    REGION_LSB = 16,
    parameter int                    CH_LSB     = 12,
    parameter int                    TIMEOUT    = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    output logic                       stall,
    output logic                       rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic [7:0]                 err_cnt,
    output logic [N_CH-1:0]            ch_sel,
    output logic                       ch_we,
    output logic [CH_LSB-1:0]          ch_addr,
    output logic [DATA_WIDTH-1:0]      ch_wdata,
    input  logic [N_CH*DATA_WIDTH-1:0] ch_rdata,
    input  logic [N_CH-1:0]            ch_ready
);

    localparam int CH_BITS = $clog2(N_CH);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   tmo_cnt;

    logic [CH_BITS-1:0] req_ch;
    logic               region_hit;
    logic               ch_hit;
    logic               dec_hit;
    logic [N_CH-1:0]    req_onehot;

    logic               sel_ready;
    logic [DATA_WIDTH-1:0] sel_rdata;

    assign req_ch     = req_addr[CH_LSB +: CH_BITS];
    assign region_hit = (req_addr[ADDR_WIDTH-1:REGION_LSB] == BASE_ADDR[ADDR_WIDTH-1:REGION_LSB]);
    // Only matters when N_CH is not a power of two.
    assign ch_hit     = (32'(req_ch) < 32'(N_CH));
    assign dec_hit    = region_hit && ch_hit;
    assign req_onehot = N_CH'(1) << req_ch;

    // ch_sel is one-hot during ACCESS, so it masks out stray ready/data from other channels.
    assign sel_ready = |(ch_sel & ch_ready);

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_sel[k]) begin
                sel_rdata = sel_rdata | ch_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Gated with reset so the pipeline is released the instant reset asserts.
    assign stall = reset && (((state == ST_IDLE) && req_valid) || (state == ST_ACCESS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            err_cnt   <= 8'h00;
            ch_sel    <= '0;
            ch_we     <= 1'b0;
            ch_addr   <= '0;
            ch_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (dec_hit) begin
                            state    <= ST_ACCESS;
                            ch_sel   <= req_onehot;
                            ch_we    <= req_write;
                            ch_addr  <= req_addr[CH_LSB-1:0];
                            ch_wdata <= req_wdata;
                            tmo_cnt  <= '0;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (sel_ready) begin
                        state     <= ST_RESP;
                        ch_sel    <= '0;
                        ch_we     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= ch_we ? '0 : sel_rdata;
                    end else if (tmo_cnt == CNT_LAST) begin
                        state     <= ST_RESP;
                        ch_sel    <= '0;
                        ch_we     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    if (rsp_err && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'h01;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized bench for mem_bus_ctrl against a cycle-count reference model of each access.
module tb_mem_bus_ctrl;

    localparam int DW      = 32;
    localparam int NCH     = 4;
    localparam int TMO     = 15;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_write;
    logic [31:0]     req_addr;
    logic [DW-1:0]   req_wdata;
    logic            stall;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [7:0]      err_cnt;
    logic [NCH-1:0]  ch_sel;
    logic            ch_we;
    logic [11:0]     ch_addr;
    logic [DW-1:0]   ch_wdata;
    logic [NCH*DW-1:0] ch_rdata;
    logic [NCH-1:0]  ch_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: last response and the saturating error count.
    logic [31:0] m_last_rd  = 32'h0;
    logic        m_last_err = 1'b0;
    int          m_cnt      = 0;
    logic [31:0] chdat [NCH];

    mem_bus_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(32), .N_CH(NCH), .BASE_ADDR(BASE),
        .REGION_LSB(16), .CH_LSB(12), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .err_cnt(err_cnt), .ch_sel(ch_sel), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_ready(ch_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access from request to response. wait_n = ACCESS cycles before the target's
    // ready (ready lands in ACCESS cycle wait_n+1). stray_all forces other channels ready.
    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input int wait_n, input logic stray_all);
        logic        hit;
        int          k;
        int          rsp_n;
        logic        e_err;
        logic [31:0] e_rd;
        logic [NCH-1:0] e_sel;
        logic [NCH-1:0] rdy;
        logic [31:0] hi_a, hi_b;
        k    = int'((addr >> 12) % (1 << $clog2(NCH)));
        hi_a = addr >> 16;
        hi_b = BASE >> 16;
        hit  = (hi_a == hi_b) && (k < NCH);
        if (!hit) begin
            rsp_n = 1; e_err = 1'b1; e_rd = 32'h0;
        end else if (wait_n + 1 <= TMO) begin
            rsp_n = wait_n + 2; e_err = 1'b0; e_rd = wr ? 32'h0 : chdat[k];
        end else begin
            rsp_n = TMO + 1; e_err = 1'b1; e_rd = 32'h0;
        end
        for (int n = 0; n <= rsp_n; n++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_write = wr;
            req_addr  = addr;
            req_wdata = wdata;
            for (int c = 0; c < NCH; c++) ch_rdata[c*DW +: DW] = chdat[c];
            rdy = stray_all ? {NCH{1'b1}} : NCH'($urandom);
            if (hit) begin
                if (n == 0 || n == rsp_n) rdy[k] = 1'($urandom);
                else rdy[k] = (n == wait_n + 1);
            end
            ch_ready = rdy;
            #1;
            e_sel = (hit && n >= 1 && n < rsp_n) ? (NCH'(1) << k) : '0;
            n_checks++;
            if (stall !== (n < rsp_n)) begin
                n_fail++;
                $display("FAIL stall addr=%h cyc=%0d got=%b exp=%b", addr, n, stall, (n < rsp_n));
            end
            n_checks++;
            if (rsp_valid !== (n == rsp_n)) begin
                n_fail++;
                $display("FAIL rsp_valid addr=%h cyc=%0d got=%b exp=%b", addr, n, rsp_valid, (n == rsp_n));
            end
            n_checks++;
            if (ch_sel !== e_sel) begin
                n_fail++;
                $display("FAIL ch_sel addr=%h cyc=%0d got=%b exp=%b", addr, n, ch_sel, e_sel);
            end
            if (e_sel != '0) begin
                n_checks++;
                if (ch_we !== wr || ch_addr !== addr[11:0] || ch_wdata !== wdata) begin
                    n_fail++;
                    $display("FAIL ch_bus addr=%h cyc=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h",
                             addr, n, ch_we, ch_addr, ch_wdata, wr, addr[11:0], wdata);
                end
            end
            n_checks++;
            if (n == rsp_n) begin
                if (rsp_rdata !== e_rd || rsp_err !== e_err) begin
                    n_fail++;
                    $display("FAIL rsp_data addr=%h got rd=%h err=%b exp rd=%h err=%b",
                             addr, rsp_rdata, rsp_err, e_rd, e_err);
                end
            end else begin
                if (rsp_rdata !== m_last_rd || rsp_err !== m_last_err) begin
                    n_fail++;
                    $display("FAIL rsp_hold addr=%h cyc=%0d got rd=%h err=%b exp rd=%h err=%b",
                             addr, n, rsp_rdata, rsp_err, m_last_rd, m_last_err);
                end
            end
            if (n < rsp_n) begin
                n_checks++;
                if (err_cnt !== 8'(m_cnt)) begin
                    n_fail++;
                    $display("FAIL err_cnt addr=%h cyc=%0d got=%0d exp=%0d", addr, n, err_cnt, m_cnt);
                end
            end
        end
        m_last_rd  = e_rd;
        m_last_err = e_err;
        if (e_err && m_cnt < 255) m_cnt++;
    endtask

    task automatic idle_cycles(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            ch_ready  = NCH'($urandom);
            #1;
            n_checks++;
            if (stall !== 1'b0 || rsp_valid !== 1'b0 || ch_sel !== '0) begin
                n_fail++;
                $display("FAIL idle cyc=%0d got stall=%b vld=%b sel=%b exp 0 0 0", n, stall, rsp_valid, ch_sel);
            end
            n_checks++;
            if (err_cnt !== 8'(m_cnt) || rsp_rdata !== m_last_rd || rsp_err !== m_last_err) begin
                n_fail++;
                $display("FAIL idle_regs got cnt=%0d rd=%h err=%b exp cnt=%0d rd=%h err=%b",
                         err_cnt, rsp_rdata, rsp_err, m_cnt, m_last_rd, m_last_err);
            end
        end
    endtask

    task automatic randomize_chdat();
        for (int c = 0; c < NCH; c++) chdat[c] = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        ch_rdata = '0; ch_ready = '0;
        randomize_chdat();
        #12;
        n_checks++;
        if (stall !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 ||
            err_cnt !== 8'h00 || ch_sel !== '0 || ch_we !== 1'b0 || ch_addr !== '0 || ch_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_state got stall=%b vld=%b rd=%h err=%b cnt=%h sel=%b we=%b a=%h d=%h exp all 0",
                     stall, rsp_valid, rsp_rdata, rsp_err, err_cnt, ch_sel, ch_we, ch_addr, ch_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_load_ch1();
        randomize_chdat();
        chdat[1] = 32'hDEAD_BEEF;
        do_access(1'b0, 32'h1001_1004, 32'h0, 0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_store_wait3();
        randomize_chdat();
        do_access(1'b1, 32'h1001_0010, 32'h0000_0055, 3, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_miss();
        do_access(1'b0, 32'h2000_0000, 32'h0, 0, 1'b0);
        idle_cycles(1);
        n_checks++;
        if (err_cnt !== 8'h01) begin
            n_fail++;
            $display("FAIL miss_err_cnt got=%0d exp=1", err_cnt);
        end
    endtask

    task automatic test_timeout();
        randomize_chdat();
        do_access(1'b0, 32'h1001_2000, 32'h0, TMO + 5, 1'b0);
        do_access(1'b0, 32'h1001_2008, 32'h0, TMO - 1, 1'b0);
        do_access(1'b0, 32'h1001_2010, 32'h0, TMO, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_stray();
        randomize_chdat();
        do_access(1'b0, 32'h1001_1020, 32'h0, 4, 1'b1);
        do_access(1'b1, 32'h1001_1024, 32'hA5A5_0001, 2, 1'b1);
        idle_cycles(1);
    endtask

    task automatic test_boundaries();
        randomize_chdat();
        do_access(1'b0, 32'h1000_FFFC, 32'h0, 0, 1'b0);
        do_access(1'b0, 32'h1001_FFFC, 32'h0, 1, 1'b0);
        do_access(1'b0, 32'h1002_0000, 32'h0, 0, 1'b0);
        do_access(1'b1, 32'h1001_3FFC, 32'hFFFF_FFFF, 0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            randomize_chdat();
            if ($urandom_range(0, 4) == 0)
                a = {16'h1002 + 16'($urandom_range(0, 100)), 16'($urandom)};
            else
                a = BASE | (32'($urandom_range(0, NCH - 1)) << 12) | ($urandom & 32'h0000_0FFC);
            do_access(1'($urandom), a, $urandom, $urandom_range(0, TMO + 2), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end
    endtask

    task automatic test_reset_mid_access();
        randomize_chdat();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1001_1000; req_wdata = '0;
            ch_ready = 4'b0000;
        end
        #1;
        n_checks++;
        if (ch_sel !== 4'b0010 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_access got sel=%b stall=%b exp sel=0010 stall=1", ch_sel, stall);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (ch_sel !== '0 || stall !== 1'b0 || rsp_valid !== 1'b0 || err_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset got sel=%b stall=%b vld=%b cnt=%0d exp 0 0 0 0",
                     ch_sel, stall, rsp_valid, err_cnt);
        end
        m_cnt = 0; m_last_rd = 32'h0; m_last_err = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        ch_ready  = 4'b0010;
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(4);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 258; i++) begin
            do_access(1'b0, 32'h3000_0000 | ($urandom & 32'h0FFF_FFFC), 32'h0, 0, 1'b0);
        end
        idle_cycles(1);
        n_checks++;
        if (err_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL err_cnt_sat got=%h exp=ff", err_cnt);
        end
        do_access(1'b0, 32'h1001_0000, 32'h0, 0, 1'b0);
        idle_cycles(1);
    endtask

    initial begin
        test_reset();
        test_load_ch1();
        test_store_wait3();
        test_miss();
        test_timeout();
        test_stray();
        test_boundaries();
        test_back_to_back_random();
        test_reset_mid_access();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
